// File: rtl/rename_map_ckpt_if.sv
// Rename unit bus: the decode-side offer, the dispatch-side result, and the
// commit / mispredict / branch-resolve side-band traffic.
interface rename_map_ckpt_if #(
  parameter int ARCH_W = 5,
  parameter int PHYS_W = 6,
  parameter int CKPT_W = 2
) ();
  logic              in_valid;
  logic              in_ready;
  logic [ARCH_W-1:0] in_src1;
  logic [ARCH_W-1:0] in_src2;
  logic [ARCH_W-1:0] in_dest;
  logic              in_dest_en;
  logic              in_ckpt;

  logic              out_valid;
  logic              out_ready;
  logic [PHYS_W-1:0] out_psrc1;
  logic [PHYS_W-1:0] out_psrc2;
  logic [PHYS_W-1:0] out_pdest;
  logic [PHYS_W-1:0] out_pdest_old;
  logic              out_dest_en;
  logic [CKPT_W-1:0] out_ckpt_id;
  logic              out_ckpt;

  logic              commit_en;
  logic [PHYS_W-1:0] commit_preg;
  logic              restore_en;
  logic [CKPT_W-1:0] restore_id;
  logic              release_en;

  logic [PHYS_W:0]   free_cnt;
  logic [CKPT_W:0]   ckpt_cnt;

  modport master (
    output in_valid, in_src1, in_src2, in_dest, in_dest_en, in_ckpt,
    output out_ready, commit_en, commit_preg, restore_en, restore_id, release_en,
    input  in_ready, out_valid, out_psrc1, out_psrc2, out_pdest, out_pdest_old,
    input  out_dest_en, out_ckpt_id, out_ckpt, free_cnt, ckpt_cnt
  );

  modport slave (
    input  in_valid, in_src1, in_src2, in_dest, in_dest_en, in_ckpt,
    input  out_ready, commit_en, commit_preg, restore_en, restore_id, release_en,
    output in_ready, out_valid, out_psrc1, out_psrc2, out_pdest, out_pdest_old,
    output out_dest_en, out_ckpt_id, out_ckpt, free_cnt, ckpt_cnt
  );
endinterface

// File: rtl/rename_map_ckpt.sv
// Single-issue register rename with a circular free list and a ring of
// map checkpoints so a mispredict restores the whole map in one cycle.
// The free count is derived from the free-list pointers, so a restore only
// needs to rewind the head pointer.
module rename_map_ckpt #(
  parameter int ARCH_REGS      = 32,
  parameter int PHYS_REGS      = 64,
  parameter int NUM_CKPT       = 4,
  parameter int ARCH_W         = $clog2(ARCH_REGS),
  parameter int PHYS_W         = $clog2(PHYS_REGS),
  parameter int CKPT_W         = $clog2(NUM_CKPT),
  parameter bit ZERO_REG_FIXED = 1'b1
) (
  input logic              CLK,
  input logic              RESET,
  rename_map_ckpt_if.slave bus
);
  localparam int FREE_MAX = PHYS_REGS - ARCH_REGS;

  logic [PHYS_W-1:0] mapTable     [ARCH_REGS];
  logic [PHYS_W-1:0] freeList     [PHYS_REGS];
  logic [PHYS_W-1:0] freeHead;
  logic [PHYS_W-1:0] freeTail;
  logic [PHYS_W-1:0] ckptMap      [NUM_CKPT][ARCH_REGS];
  logic [PHYS_W-1:0] ckptFreeHead [NUM_CKPT];
  logic [CKPT_W-1:0] ckptHead;
  logic [CKPT_W-1:0] ckptTail;
  logic [CKPT_W:0]   ckptCnt;

  logic              outValid;
  logic [PHYS_W-1:0] outPsrc1;
  logic [PHYS_W-1:0] outPsrc2;
  logic [PHYS_W-1:0] outPdest;
  logic [PHYS_W-1:0] outPdestOld;
  logic              outDestEn;
  logic [CKPT_W-1:0] outCkptId;
  logic              outCkpt;

  logic [PHYS_W-1:0] freeCount;
  logic              freeFull;
  logic              ckptFull;
  logic              effDest;
  logic              inReady;
  logic              accept;
  logic              doPop;
  logic              doPush;
  logic              takeCkpt;
  logic [PHYS_W-1:0] newPdest;
  logic [CKPT_W-1:0] restoreOffset;
  logic              restoreHit;
  logic [CKPT_W:0]   cntBase;
  logic              releaseOk;

  assign freeCount = freeTail - freeHead;
  assign freeFull  = (freeCount == PHYS_W'(FREE_MAX));
  assign ckptFull  = (ckptCnt == (CKPT_W+1)'(NUM_CKPT));
  assign effDest   = bus.in_dest_en && !(ZERO_REG_FIXED && (bus.in_dest == '0));
  assign inReady   = !bus.restore_en && (!outValid || bus.out_ready) &&
                     (!effDest || (freeCount != '0)) && (!bus.in_ckpt || !ckptFull);
  assign accept    = bus.in_valid && inReady;
  assign doPop     = accept && effDest;
  assign takeCkpt  = accept && bus.in_ckpt;
  assign doPush    = bus.commit_en && !freeFull;
  assign newPdest  = freeList[freeHead];

  assign restoreOffset = bus.restore_id - ckptHead;
  assign restoreHit    = bus.restore_en && ({1'b0, restoreOffset} < ckptCnt);
  assign cntBase       = restoreHit ? ({1'b0, restoreOffset} + (CKPT_W+1)'(1)) : ckptCnt;
  assign releaseOk     = bus.release_en && (cntBase != '0);

  // Map table and free list: commit always pushes; restore rewinds, otherwise rename pops.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < ARCH_REGS; i++) mapTable[i] <= PHYS_W'(i);
      for (int i = 0; i < PHYS_REGS; i++) freeList[i] <= (i < FREE_MAX) ? PHYS_W'(i + ARCH_REGS) : '0;
      freeHead <= '0;
      freeTail <= PHYS_W'(FREE_MAX);
    end else begin
      if (doPush) begin
        freeList[freeTail] <= bus.commit_preg;
        freeTail           <= freeTail + PHYS_W'(1);
      end
      if (restoreHit) begin
        for (int i = 0; i < ARCH_REGS; i++) mapTable[i] <= ckptMap[bus.restore_id][i];
        freeHead <= ckptFreeHead[bus.restore_id];
      end else if (doPop) begin
        mapTable[bus.in_dest] <= newPdest;
        freeHead              <= freeHead + PHYS_W'(1);
      end
    end
  end

  // Snapshot storage holds the post-rename map and post-pop head of a branch.
  always_ff @(posedge CLK) begin
    if (!RESET && takeCkpt) begin
      for (int i = 0; i < ARCH_REGS; i++)
        ckptMap[ckptTail][i] <= (doPop && (bus.in_dest == ARCH_W'(i))) ? newPdest : mapTable[i];
      ckptFreeHead[ckptTail] <= doPop ? freeHead + PHYS_W'(1) : freeHead;
    end
  end

  // Checkpoint ring bookkeeping: restore trims younger slots, then release retires the oldest.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ckptHead <= '0;
      ckptTail <= '0;
      ckptCnt  <= '0;
    end else begin
      if (restoreHit)    ckptTail <= bus.restore_id + CKPT_W'(1);
      else if (takeCkpt) ckptTail <= ckptTail + CKPT_W'(1);
      if (releaseOk)     ckptHead <= ckptHead + CKPT_W'(1);
      ckptCnt <= cntBase + (CKPT_W+1)'(takeCkpt) - (CKPT_W+1)'(releaseOk);
    end
  end

  // Registered rename result with squash on restore and hold while downstream stalls.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      outValid    <= 1'b0;
      outPsrc1    <= '0;
      outPsrc2    <= '0;
      outPdest    <= '0;
      outPdestOld <= '0;
      outDestEn   <= 1'b0;
      outCkptId   <= '0;
      outCkpt     <= 1'b0;
    end else if (bus.restore_en) begin
      outValid <= 1'b0;
    end else if (accept) begin
      outValid    <= 1'b1;
      outPsrc1    <= mapTable[bus.in_src1];
      outPsrc2    <= mapTable[bus.in_src2];
      outPdest    <= effDest ? newPdest : '0;
      outPdestOld <= effDest ? mapTable[bus.in_dest] : '0;
      outDestEn   <= effDest;
      outCkptId   <= bus.in_ckpt ? ckptTail : '0;
      outCkpt     <= bus.in_ckpt;
    end else if (bus.out_ready) begin
      outValid <= 1'b0;
    end
  end

  // A commit into an already full free list means the ROB freed a register twice.
  assert property (@(posedge CLK) disable iff (RESET) !(bus.commit_en && freeFull));

  assign bus.in_ready      = inReady;
  assign bus.out_valid     = outValid;
  assign bus.out_psrc1     = outPsrc1;
  assign bus.out_psrc2     = outPsrc2;
  assign bus.out_pdest     = outPdest;
  assign bus.out_pdest_old = outPdestOld;
  assign bus.out_dest_en   = outDestEn;
  assign bus.out_ckpt_id   = outCkptId;
  assign bus.out_ckpt      = outCkpt;
  assign bus.free_cnt      = {1'b0, freeCount};
  assign bus.ckpt_cnt      = ckptCnt;
endmodule

// File: tb/tb_rename_map_ckpt.sv
// Bench for rename_map_ckpt: directed scenarios followed by random traffic,
// all checked against a queue-based model of map, free list and checkpoints.
module tb_rename_map_ckpt;
  localparam int ARCH_REGS = 32;
  localparam int PHYS_REGS = 64;
  localparam int NUM_CKPT  = 4;
  localparam int ARCH_W    = 5;
  localparam int PHYS_W    = 6;
  localparam int CKPT_W    = 2;
  localparam int FREE_MAX  = PHYS_REGS - ARCH_REGS;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  rename_map_ckpt_if #(.ARCH_W(ARCH_W), .PHYS_W(PHYS_W), .CKPT_W(CKPT_W)) bus ();

  rename_map_ckpt #(
    .ARCH_REGS(ARCH_REGS), .PHYS_REGS(PHYS_REGS), .NUM_CKPT(NUM_CKPT),
    .ARCH_W(ARCH_W), .PHYS_W(PHYS_W), .CKPT_W(CKPT_W), .ZERO_REG_FIXED(1'b1)
  ) dut (
    .CLK(clock),
    .RESET(reset),
    .bus(bus)
  );

  typedef struct packed {
    logic [ARCH_REGS-1:0][PHYS_W-1:0] snapMap;
    int                               pops;
    int                               id;
  } CkptSnap;

  logic [ARCH_REGS-1:0][PHYS_W-1:0] mMap;
  int      fifo [0:8191];
  int      pushes;
  int      pops;
  int      nextId;
  CkptSnap ckq [$];

  bit eValid;
  int ePsrc1, ePsrc2, ePdest, ePdestOld, eCkptId;
  bit eDestEn, eCkpt;

  int totalCnt = 0;
  int passCnt  = 0;

  // The model's free list is an unbounded array indexed by absolute push/pop counts.
  function automatic void modelReset();
    for (int i = 0; i < ARCH_REGS; i++) mMap[i] = PHYS_W'(i);
    for (int i = 0; i < FREE_MAX; i++) fifo[i] = ARCH_REGS + i;
    pushes = FREE_MAX;
    pops   = 0;
    nextId = 0;
    ckq.delete();
    eValid = 0; ePsrc1 = 0; ePsrc2 = 0; ePdest = 0; ePdestOld = 0;
    eDestEn = 0; eCkpt = 0; eCkptId = 0;
  endfunction

  function automatic int modelFree();
    return pushes - pops;
  endfunction

  // Commits are limited so no recoverable (checkpointed) entry is ever overwritten.
  function automatic bit canCommit();
    int minPops;
    minPops = (ckq.size() > 0) ? ckq[0].pops : pops;
    return ((pushes - minPops) < FREE_MAX) && (modelFree() < FREE_MAX);
  endfunction

  function automatic bit modelReady();
    bit effDest;
    effDest = bus.in_dest_en && (bus.in_dest != '0);
    return !bus.restore_en && (!eValid || bus.out_ready) &&
           (!effDest || modelFree() != 0) && (!bus.in_ckpt || ckq.size() != NUM_CKPT);
  endfunction

  function automatic void modelEdge();
    bit      acc;
    bit      effDest;
    int      sizeBefore;
    int      found;
    CkptSnap snap;
    if (reset) begin
      modelReset();
      return;
    end
    effDest    = bus.in_dest_en && (bus.in_dest != '0);
    acc        = bus.in_valid && modelReady();
    sizeBefore = ckq.size();
    if (bus.commit_en && modelFree() != FREE_MAX) begin
      fifo[pushes] = int'(bus.commit_preg);
      pushes++;
    end
    if (bus.restore_en) begin
      found = -1;
      for (int k = 0; k < ckq.size(); k++)
        if (ckq[k].id == int'(bus.restore_id)) found = k;
      if (found >= 0) begin
        mMap = ckq[found].snapMap;
        pops = ckq[found].pops;
        while (ckq.size() > found + 1) void'(ckq.pop_back());
        nextId = (int'(bus.restore_id) + 1) % NUM_CKPT;
      end
      eValid = 0;
      if (bus.release_en && ckq.size() > 0) void'(ckq.pop_front());
    end else begin
      if (acc) begin
        eValid  = 1;
        ePsrc1  = int'(mMap[bus.in_src1]);
        ePsrc2  = int'(mMap[bus.in_src2]);
        eDestEn = effDest;
        if (effDest) begin
          ePdestOld          = int'(mMap[bus.in_dest]);
          ePdest             = fifo[pops];
          pops++;
          mMap[bus.in_dest]  = PHYS_W'(ePdest);
        end else begin
          ePdestOld = 0;
          ePdest    = 0;
        end
        eCkpt   = bus.in_ckpt;
        eCkptId = bus.in_ckpt ? nextId : 0;
        if (bus.in_ckpt) begin
          snap.snapMap = mMap;
          snap.pops    = pops;
          snap.id      = nextId;
          ckq.push_back(snap);
          nextId = (nextId + 1) % NUM_CKPT;
        end
      end else if (bus.out_ready) begin
        eValid = 0;
      end
      if (bus.release_en && sizeBefore > 0) void'(ckq.pop_front());
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt = passCnt + 1;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic checkAll(input bit full);
    checkOutput("out_valid", 32'(bus.out_valid), 32'(eValid));
    if (eValid || full) begin
      checkOutput("out_psrc1", 32'(bus.out_psrc1), ePsrc1);
      checkOutput("out_psrc2", 32'(bus.out_psrc2), ePsrc2);
      checkOutput("out_pdest", 32'(bus.out_pdest), ePdest);
      checkOutput("out_pdest_old", 32'(bus.out_pdest_old), ePdestOld);
      checkOutput("out_dest_en", 32'(bus.out_dest_en), 32'(eDestEn));
      checkOutput("out_ckpt", 32'(bus.out_ckpt), 32'(eCkpt));
    end
    if ((eValid && eCkpt) || full) checkOutput("out_ckpt_id", 32'(bus.out_ckpt_id), eCkptId);
    checkOutput("free_cnt", 32'(bus.free_cnt), modelFree());
    checkOutput("ckpt_cnt", 32'(bus.ckpt_cnt), ckq.size());
  endtask

  task automatic setIdle();
    bus.in_valid    = 1'b0;
    bus.in_src1     = '0;
    bus.in_src2     = '0;
    bus.in_dest     = '0;
    bus.in_dest_en  = 1'b0;
    bus.in_ckpt     = 1'b0;
    bus.out_ready   = 1'b1;
    bus.commit_en   = 1'b0;
    bus.commit_preg = '0;
    bus.restore_en  = 1'b0;
    bus.restore_id  = '0;
    bus.release_en  = 1'b0;
  endtask

  task automatic setRename(input bit v, input int s1, input int s2, input int d, input bit de, input bit ck);
    bus.in_valid   = v;
    bus.in_src1    = ARCH_W'(s1);
    bus.in_src2    = ARCH_W'(s2);
    bus.in_dest    = ARCH_W'(d);
    bus.in_dest_en = de;
    bus.in_ckpt    = ck;
  endtask

  // One clock: check readiness before the edge, advance the model, check results after it.
  task automatic applyStimulus();
    bit expReady;
    #1;
    if (!reset) begin
      expReady = modelReady();
      checkOutput("in_ready", 32'(bus.in_ready), 32'(expReady));
    end
    @(posedge clock);
    modelEdge();
    #1;
    checkAll(reset);
    setIdle();
  endtask

  initial begin
    $display("[TB] rename_map_ckpt bench starting");
    setIdle();
    modelReset();

    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    checkOutput("reset_free_cnt", 32'(bus.free_cnt), 32);
    checkOutput("reset_ckpt_cnt", 32'(bus.ckpt_cnt), 0);

    setRename(1, 5, 3, 5, 1, 0);
    applyStimulus();
    checkOutput("first_psrc1", 32'(bus.out_psrc1), 5);
    checkOutput("first_psrc2", 32'(bus.out_psrc2), 3);
    checkOutput("first_pdest", 32'(bus.out_pdest), 32);
    checkOutput("first_pdest_old", 32'(bus.out_pdest_old), 5);
    checkOutput("first_free_cnt", 32'(bus.free_cnt), 31);

    setRename(1, 5, 0, 0, 1, 0);
    applyStimulus();
    checkOutput("renamed_src", 32'(bus.out_psrc1), 32);
    checkOutput("zero_dest_en", 32'(bus.out_dest_en), 0);
    checkOutput("zero_pdest", 32'(bus.out_pdest), 0);
    checkOutput("zero_free_cnt", 32'(bus.free_cnt), 31);

    for (int n = 0; n < 40 && modelFree() > 0; n++) begin
      setRename(1, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(1, 31), 1, 0);
      applyStimulus();
    end
    setRename(1, 1, 2, 4, 1, 0);
    applyStimulus();
    checkOutput("drained_free_cnt", 32'(bus.free_cnt), 0);

    bus.commit_en   = 1'b1;
    bus.commit_preg = PHYS_W'(7);
    applyStimulus();
    checkOutput("one_commit_free_cnt", 32'(bus.free_cnt), 1);
    setRename(1, 0, 0, 9, 1, 0);
    applyStimulus();
    checkOutput("wrap_pdest", 32'(bus.out_pdest), 7);

    for (int n = 0; n < 30; n++) begin
      bus.commit_en   = canCommit();
      bus.commit_preg = PHYS_W'($urandom_range(1, 63));
      applyStimulus();
    end

    setRename(1, 1, 2, 0, 0, 1);
    applyStimulus();
    checkOutput("branch_ckpt", 32'(bus.out_ckpt), 1);
    checkOutput("branch_ckpt_id", 32'(bus.out_ckpt_id), 0);
    checkOutput("branch_free_cnt", 32'(bus.free_cnt), 30);
    for (int d = 10; d <= 12; d++) begin
      setRename(1, 0, 0, d, 1, 0);
      applyStimulus();
    end
    bus.restore_en = 1'b1;
    bus.restore_id = '0;
    applyStimulus();
    checkOutput("restore_squash", 32'(bus.out_valid), 0);
    checkOutput("restore_free_cnt", 32'(bus.free_cnt), 30);
    setRename(1, 10, 11, 12, 1, 0);
    applyStimulus();

    bus.release_en = 1'b1;
    applyStimulus();
    checkOutput("release_ckpt_cnt", 32'(bus.ckpt_cnt), 0);
    for (int n = 0; n < 4; n++) begin
      setRename(1, n, n, 0, 0, 1);
      applyStimulus();
    end
    checkOutput("full_ckpt_cnt", 32'(bus.ckpt_cnt), 4);
    setRename(1, 1, 1, 0, 0, 1);
    applyStimulus();
    setRename(1, 1, 1, 0, 0, 1);
    bus.release_en = 1'b1;
    applyStimulus();
    checkOutput("stall_release_cnt", 32'(bus.ckpt_cnt), 3);
    setRename(1, 1, 1, 0, 0, 1);
    applyStimulus();
    checkOutput("late_branch_ckpt", 32'(bus.out_ckpt), 1);
    checkOutput("late_branch_cnt", 32'(bus.ckpt_cnt), 4);

    setRename(1, 3, 4, 5, 1, 0);
    applyStimulus();
    for (int n = 0; n < 3; n++) begin
      setRename(1, 6, 7, 8, 1, 0);
      bus.out_ready = 1'b0;
      applyStimulus();
    end
    bus.commit_en   = canCommit();
    bus.commit_preg = PHYS_W'(50);
    bus.restore_en  = 1'b1;
    bus.restore_id  = CKPT_W'(ckq[0].id);
    applyStimulus();
    checkOutput("commit_restore_cnt", 32'(bus.ckpt_cnt), 1);
    for (int n = 0; n < 40 && modelFree() > 0; n++) begin
      setRename(1, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(1, 31), 1, 0);
      applyStimulus();
    end

    setRename(1, 2, 2, 0, 0, 1);
    applyStimulus();
    reset = 1'b1;
    setRename(1, 4, 4, 4, 1, 1);
    applyStimulus();
    reset = 1'b0;
    checkOutput("midreset_ckpt_cnt", 32'(bus.ckpt_cnt), 0);
    checkOutput("midreset_free_cnt", 32'(bus.free_cnt), 32);

    for (int n = 0; n < 600; n++) begin
      setRename($urandom_range(0, 9) < 7, $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 31), $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2);
      bus.out_ready   = ($urandom_range(0, 3) != 0);
      bus.commit_en   = ($urandom_range(0, 9) < 4) && canCommit();
      bus.commit_preg = PHYS_W'($urandom_range(0, 63));
      bus.restore_en  = ($urandom_range(0, 19) == 0);
      bus.restore_id  = CKPT_W'($urandom_range(0, 3));
      bus.release_en  = ($urandom_range(0, 9) < 2);
      applyStimulus();
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
